instruction_fetch: RTL

Fetch stage of the RV32E core, directly upstream of the program ROM. Holds the program counter and drives the ROM's word-indexed address. Captures the returned instruction into a 2-entry buffer and presents it to decode with a valid/ready handshake. Accepts control-flow redirects from execute and flags misaligned or out-of-range fetches.

---
 rtl/instruction_fetch_pkg.sv | 22 ++
 rtl/instruction_fetch_fetch_buffer.sv | 63 ++++++
 rtl/instruction_fetch.sv | 87 ++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the RV32E fetch stage: NOP encoding, PC step,
// buffer depth, FSM states and the buffered entry layout.
package instruction_fetch_pkg;

  localparam logic [31:0] I_NOP       = 32'h0000_0013;
  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam logic [1:0]  FETCH_DEPTH = 2'd2;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  localparam fetch_entry_t NOP_ENTRY = '{inst: I_NOP, pc: 32'h0000_0000, fault: 1'b0};

endpackage

// File: rtl/instruction_fetch_fetch_buffer.sv
// Two-entry synchronous FIFO of fetched entries. When empty it keeps presenting
// the most recently written slot so the outputs never change without a write.
module fetch_buffer
  import instruction_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t data_o,
  output logic [1:0]   count_o
);

  fetch_entry_t slots_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         push_en_s;
  logic         pop_en_s;

  assign pop_en_s  = pop_i & (count_q != 2'd0);
  assign push_en_s = push_i & ((count_q < FETCH_DEPTH) | pop_en_s);

  // Occupancy update from the push/pop combination
  always_comb begin
    count_d = count_q;
    case ({push_en_s, pop_en_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Slot storage, pointers and occupancy; flush keeps slot contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_q[0] <= NOP_ENTRY;
      slots_q[1] <= NOP_ENTRY;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= wr_ptr_q;
      count_q  <= 2'd0;
    end else begin
      if (push_en_s) begin
        slots_q[wr_ptr_q] <= data_i;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop_en_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign data_o  = (count_q == 2'd0) ? slots_q[~wr_ptr_q] : slots_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// RV32E fetch stage: owns the PC, drives the ROM word address, buffers fetched
// words for decode and turns misaligned/out-of-range fetches into fault markers.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] ROM_WORDS = 32'd513
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [1:0]   count_s;
  logic         pop_s;
  logic         push_s;
  logic         pc_ok_s;
  fetch_entry_t entry_s;
  fetch_entry_t head_s;

  assign pc_ok_s = (pc_q[1:0] == 2'b00) && ({2'b00, pc_q[31:2]} < ROM_WORDS);
  assign pop_s   = inst_valid & inst_ready;

  // Redirect wins; otherwise fetch whenever the buffer has (or is freeing) room
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push_s  = 1'b0;
    entry_s = '{inst: rom_data, pc: pc_q, fault: 1'b0};
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = ST_RUN;
    end else if ((state_q == ST_RUN) && ((count_s < FETCH_DEPTH) || pop_s)) begin
      push_s = 1'b1;
      if (pc_ok_s) begin
        pc_d = pc_q + PC_STEP;
      end else begin
        entry_s.inst  = I_NOP;
        entry_s.fault = 1'b1;
        state_d       = ST_FAULT;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // PC and fetch state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s & ~redirect_valid),
    .flush_i (redirect_valid),
    .data_i  (entry_s),
    .data_o  (head_s),
    .count_o (count_s)
  );

  assign rom_addr   = {2'b00, pc_q[31:2]};
  assign inst_valid = (count_s != 2'd0);
  assign inst       = head_s.inst;
  assign inst_pc    = head_s.pc;
  assign inst_fault = head_s.fault;

endmodule
